rsa_result_tx: RTL and testbench
================================

RSA_RESULT_TX -- requirements
Module: rsa_result_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, which sets clock cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have port clk, input, 1, system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-004 The block SHALL have port start, input, 1, level request from the RSA I/O stage (its completion flag); only the rising edge is acted on.
REQ-005 The block SHALL have port data_in, input, 32, RSA result word to transmit.
REQ-006 The block SHALL have port tx, output, 1, UART 8N1 serial line, idle high.
REQ-007 The block SHALL have port busy, output, 1, high while a word is being transmitted.
REQ-008 The block SHALL have port done, output, 1, one-cycle pulse when the full 32-bit word has been sent.

Function
REQ-009 The block SHALL register start into start_d each cycle and detect a rising edge as start=1 with start_d=0.
REQ-010 The block SHALL implement the states IDLE, START_BIT, DATA_BITS and STOP_BIT.
REQ-011 In IDLE, a detected edge SHALL latch data_in into a 32-bit shift register, clear the byte index, and enter START_BIT on the next cycle.
REQ-012 On that next cycle, tx SHALL go 0 and busy SHALL go 1 (one-cycle latency from the edge sample).
REQ-013 Each bit (start, data and stop) SHALL hold tx for exactly CLKS_PER_BIT cycles.
- Timing comes from a baud counter that counts 0..CLKS_PER_BIT-1.
- The baud counter resets to 0 on every bit boundary.
REQ-014 START_BIT SHALL drive tx=0, then enter DATA_BITS with bit index 0.
REQ-015 DATA_BITS SHALL drive the current byte LSB first, bit index 0..7, then enter STOP_BIT.
REQ-016 STOP_BIT SHALL drive tx=1.
- If the byte index < 3, it then increments the byte index and enters START_BIT.
- Otherwise it enters IDLE.
REQ-017 Byte order SHALL be most significant first: data[31:24], [23:16], [15:8], [7:0].
REQ-018 There SHALL be no idle gap between bytes; the stop bit is immediately followed by the next start bit.
REQ-019 A complete word SHALL occupy exactly 40*CLKS_PER_BIT cycles, from the first cycle of tx=0 through the last stop-bit cycle.
REQ-020 On the cycle after the last stop-bit cycle, the block SHALL:
- be in IDLE;
- drive done=1 for exactly one cycle;
- drive busy=0 and tx=1.
REQ-021 A start edge while not in IDLE SHALL be ignored, not queued; data_in changes while busy SHALL NOT affect the transmission.
REQ-022 A start edge in the same cycle that done=1 SHALL be accepted, since the state is IDLE.
REQ-023 Start held high continuously SHALL cause exactly one transmission; start must fall and rise again to retransmit.

Reset
REQ-024 While rstn=0, the outputs SHALL be tx=1, busy=0 and done=0.
REQ-025 While rstn=0, the state SHALL be IDLE and start_d, all counters and the shift register SHALL be 0.
REQ-026 Reset asserted mid-frame SHALL abort immediately: tx returns to 1 asynchronously and no done pulse is produced.
REQ-027 After release, start already high SHALL count as a rising edge on the first clock, because start_d resets to 0.

Verification (CLKS_PER_BIT=4)
REQ-028 Bench SHALL cover basic send:
- Stimulus: data_in=32'h007D_C743, start rises.
- Response: bytes 00,7D,C7,43 on tx, 160 cycles total, done pulses once, busy falls with done.
- The last byte's data bits are 1,1,0,0,0,0,1,0.
REQ-029 Bench SHALL cover bit timing: every tx level segment is a multiple of 4 cycles, and tx=0 starts exactly 1 cycle after the edge is sampled.
REQ-030 Bench SHALL cover edge ignored while busy: a second start pulse at cycle 50 with data_in=32'hFFFF_FFFF produces no change to the frame and no extra done.
REQ-031 Bench SHALL cover level start: start held high for 500 cycles gives exactly one 160-cycle frame and one done.
REQ-032 Bench SHALL cover reset mid-frame: rstn=0 at cycle 70 gives tx=1, busy=0 immediately; after release with start=0 the line stays idle and done=0.
REQ-033 Bench SHALL cover back-to-back: a new edge on the done cycle with data_in=32'h0321_78C4 yields bytes 03,21,78,C4 starting the next cycle.

Source files
------------

// File: rtl/rsa_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : rsa_result_tx
// Purpose  : Serialises a 32-bit RSA result word onto a UART 8N1 line as four
//            back-to-back bytes, most significant byte first, each byte sent
//            LSB first. A transmission is triggered by the rising edge of the
//            RSA I/O stage's completion flag.
// Ports    : clk     - system clock, rising edge
//            rstn    - asynchronous active-low reset
//            start   - level request; only its rising edge is acted on
//            data_in - 32-bit word captured on the accepted edge
//            tx      - serial line, idles high
//            busy    - high while a word is on the line
//            done    - one-cycle pulse after the last stop bit
// Revision : 1.0 - initial release
// ============================================================================
module rsa_result_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] data_in,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BITS = 2'd2,
        STOP_BIT  = 2'd3
    } state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    state_t      state_next;
    logic        start_d;
    logic [31:0] shift_reg;
    logic [1:0]  byte_idx;
    logic [2:0]  bit_idx;
    logic [15:0] baud_cnt;
    logic        done_r;
    logic        done_next;
    logic        start_edge;
    logic        baud_end;

    assign start_edge = start & ~start_d;
    assign baud_end   = (baud_cnt == BAUD_LAST);
    assign busy       = (state != IDLE);
    assign done       = done_r;

    // Next-state and line driver. tx is decoded from the state register so an
    // asynchronous reset returns the line to idle without waiting for a clock.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        tx         = 1'b1;
        case (state)
            IDLE: begin
                if (start_edge) state_next = START_BIT;
            end
            START_BIT: begin
                tx = 1'b0;
                if (baud_end) state_next = DATA_BITS;
            end
            DATA_BITS: begin
                // The byte being sent always sits in the top lane of the
                // shift register.
                tx = shift_reg[{2'b11, bit_idx}];
                if (baud_end && (bit_idx == 3'd7)) state_next = STOP_BIT;
            end
            STOP_BIT: begin
                if (baud_end) begin
                    if (byte_idx != 2'd3) begin
                        state_next = START_BIT;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            start_d   <= 1'b0;
            shift_reg <= '0;
            byte_idx  <= '0;
            bit_idx   <= '0;
            baud_cnt  <= '0;
            done_r    <= 1'b0;
        end else begin
            state   <= state_next;
            start_d <= start;
            done_r  <= done_next;

            if (state == IDLE) begin
                baud_cnt <= '0;
                if (start_edge) begin
                    shift_reg <= data_in;
                    byte_idx  <= '0;
                    bit_idx   <= '0;
                end
            end else begin
                baud_cnt <= baud_end ? 16'd0 : baud_cnt + 16'd1;
                if (baud_end) begin
                    case (state)
                        START_BIT: bit_idx <= '0;
                        DATA_BITS: bit_idx <= bit_idx + 3'd1;
                        STOP_BIT: begin
                            if (byte_idx != 2'd3) begin
                                byte_idx  <= byte_idx + 2'd1;
                                // Bring the next less-significant byte up.
                                shift_reg <= {shift_reg[23:0], 8'h00};
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rsa_result_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_rsa_result_tx
// Purpose  : Self-checking bench for rsa_result_tx with CLKS_PER_BIT = 4.
//            Expected line waveforms come from a reference model that builds
//            the 8N1 bit sequence of a word directly from the framing rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_result_tx;

    localparam int CPB   = 4;
    localparam int FRAME = 40 * CPB;
    localparam int LOGN  = 600;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] data_in;
    logic        tx;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    rsa_result_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    int   total  = 0;
    int   passed = 0;
    logic txlog   [0:LOGN-1];
    logic busylog [0:LOGN-1];
    logic donelog [0:LOGN-1];
    logic model   [0:FRAME-1];

    typedef struct {
        logic [31:0] data;
        logic [31:0] exp_word;
        int          hold;
        int          glitch;
        int          win;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference waveform: 4 bytes MSB first, each as start(0), 8 data bits
    // LSB first, stop(1); every bit lasts CPB cycles.
    task automatic build_model(input logic [31:0] d);
        int   p;
        logic [7:0] b;
        p = 0;
        for (int k = 0; k < 4; k++) begin
            b = 8'((d >> (24 - 8 * k)) & 32'hFF);
            for (int s = 0; s < 10; s++) begin
                for (int r = 0; r < CPB; r++) begin
                    if (s == 0)      model[p] = 1'b0;
                    else if (s == 9) model[p] = 1'b1;
                    else             model[p] = b[s-1];
                    p++;
                end
            end
        end
    endtask

    // Raises start, logs the line for 'win' cycles while scrambling data_in,
    // optionally re-pulsing start mid-frame, then checks the captured frame.
    task automatic run_frame(input string name, input logic [31:0] d,
                             input logic [31:0] exp_word, input int hold,
                             input int glitch, input int win);
        int          mism, dones, busy_cnt, idle_busy, bad_seg, frm_err, run_len;
        logic [31:0] dec;
        txlog[0] = tx;
        data_in  = d;
        start    = 1'b1;
        for (int c = 1; c <= win; c++) begin
            tick();
            txlog[c]   = tx;
            busylog[c] = busy;
            donelog[c] = done;
            data_in    = $urandom;
            start      = (c < hold) || (glitch > 0 && c >= glitch && c < glitch + 2);
            if (glitch > 0 && c == glitch) data_in = 32'hFFFF_FFFF;
        end

        check({name, "_idle_before"}, longint'(txlog[0]), 1);

        build_model(d);
        mism = 0;
        for (int i = 0; i < FRAME; i++) if (txlog[i+1] !== model[i]) mism++;
        check({name, "_frame_mismatches"}, mism, 0);

        dec     = '0;
        frm_err = 0;
        for (int k = 0; k < 4; k++) begin
            if (txlog[1 + (k*10) * CPB + CPB/2] !== 1'b0) frm_err++;
            if (txlog[1 + (k*10 + 9) * CPB + CPB/2] !== 1'b1) frm_err++;
            for (int b = 0; b < 8; b++)
                dec[24 - 8*k + b] = txlog[1 + (k*10 + 1 + b) * CPB + CPB/2];
        end
        check({name, "_framing_errors"}, frm_err, 0);
        check({name, "_decoded_word"}, dec, exp_word);

        bad_seg = 0;
        run_len = 1;
        for (int i = 2; i <= FRAME; i++) begin
            if (txlog[i] === txlog[i-1]) run_len++;
            else begin
                if (run_len % CPB != 0) bad_seg++;
                run_len = 1;
            end
        end
        if (run_len % CPB != 0) bad_seg++;
        check({name, "_bad_segments"}, bad_seg, 0);

        busy_cnt = 0;
        for (int i = 1; i <= FRAME; i++) if (busylog[i] === 1'b1) busy_cnt++;
        check({name, "_busy_cycles"}, busy_cnt, FRAME);

        check({name, "_done_after"}, longint'(donelog[FRAME+1]), 1);
        check({name, "_busy_after"}, longint'(busylog[FRAME+1]), 0);
        check({name, "_tx_after"},   longint'(txlog[FRAME+1]), 1);

        dones = 0;
        for (int i = 1; i <= win; i++) if (donelog[i] === 1'b1) dones++;
        check({name, "_done_count"}, dones, 1);

        idle_busy = 0;
        for (int i = FRAME + 2; i <= win; i++) if (busylog[i] !== 1'b0) idle_busy++;
        check({name, "_no_retransmit"}, idle_busy, 0);
    endtask

    initial begin
        int          n_tx0, n_busy, n_done, hold;
        logic [31:0] d;

        vecs[0] = '{32'h007D_C743, {8'h00, 8'h7D, 8'hC7, 8'h43}, 10,  0, 170};
        vecs[1] = '{32'h007D_C743, {8'h00, 8'h7D, 8'hC7, 8'h43}, 10, 50, 200};
        vecs[2] = '{32'hA5A5_5A5A, {8'hA5, 8'hA5, 8'h5A, 8'h5A}, 500, 0, 520};
        vecs[3] = '{32'hFFFF_0000, {8'hFF, 8'hFF, 8'h00, 8'h00}, 3,   0, 170};

        rstn    = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (3) tick();
        check("reset_tx",   longint'(tx),   1);
        check("reset_busy", longint'(busy), 0);
        check("reset_done", longint'(done), 0);
        rstn = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 4; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].exp_word,
                      vecs[i].hold, vecs[i].glitch, vecs[i].win);
            repeat (3) tick();
        end

        // Back-to-back: second edge raised during the done cycle.
        run_frame("b2b_first", 32'h007D_C743, {8'h00, 8'h7D, 8'hC7, 8'h43}, 10, 0, FRAME + 1);
        run_frame("b2b_second", 32'h0321_78C4, {8'h03, 8'h21, 8'h78, 8'hC4}, 10, 0, 170);
        repeat (3) tick();

        // Reset mid-frame.
        data_in = $urandom;
        start   = 1'b1;
        for (int c = 1; c <= 70; c++) begin
            tick();
            start = (c < 5);
            if (c == 69) check("midreset_busy_before", longint'(busy), 1);
        end
        rstn = 1'b0;
        #1;
        check("midreset_tx",   longint'(tx),   1);
        check("midreset_busy", longint'(busy), 0);
        check("midreset_done", longint'(done), 0);
        repeat (2) tick();
        rstn   = 1'b1;
        n_tx0  = 0;
        n_busy = 0;
        n_done = 0;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (tx !== 1'b1)   n_tx0++;
            if (busy !== 1'b0) n_busy++;
            if (done !== 1'b0) n_done++;
        end
        check("postreset_tx_low",  n_tx0,  0);
        check("postreset_busy",    n_busy, 0);
        check("postreset_done",    n_done, 0);

        // Start already high when reset releases counts as an edge.
        rstn  = 1'b0;
        start = 1'b1;
        tick();
        rstn = 1'b1;
        #1;
        d = $urandom;
        run_frame("rst_release", d, d, 10, 0, 170);
        repeat (3) tick();

        // Randomised words, hold lengths and idle gaps.
        for (int n = 0; n < 6; n++) begin
            d    = $urandom;
            hold = $urandom_range(1, 200);
            repeat ($urandom_range(1, 6)) tick();
            run_frame($sformatf("rand%0d", n), d, d, hold, 0,
                      ((hold > FRAME + 1) ? hold : FRAME + 1) + 10);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
